dbpsk_barker_tx: RTL
====================

Name: dbpsk_barker_tx

Overview:
- Transmit-side counterpart of the 32 MSps Barker matched-filter receiver.
- Accepts one data bit per 1 µs symbol through a valid/ready handshake and applies DBPSK differential encoding.
- Spreads each bit with the 11-chip 802.11b Barker sequence and emits 32 signed baseband samples per symbol, one per input strobe, for the DAC/interpolator path at 32 MSps.

Parameters:
- AMP, 16'sd8192, magnitude of each output sample (two's complement, must be < 32768).
- SPS, 32, samples per symbol; the block is specified and verified only for 32.
- CHIPS, 11, chips per symbol (Barker length); fixed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- strobe_in  in  1  sample-rate enable, one cycle high per 32 MSps sample.
- bit_in  in  1  data bit to transmit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  block can accept a bit this cycle.
- data_out  out  16  signed baseband sample.
- data_valid  out  1  data_out holds a live sample; pulses with the strobe-aligned update.
- busy  out  1  state is RUN.
- underrun  out  1  one-cycle pulse when a symbol boundary finds no bit.

Behaviour:
- Reset (reset=0, async) forces the following:
  - state=IDLE; hold register empty; bit_ready=1; data_out=0; data_valid=0; busy=0; underrun=0.
  - sample counter n=0, chip accumulator acc=0, chip index k=0, phase=+1.
- Hold register (single entry):
  - bit_ready = !hold_full.
  - A transfer occurs when bit_valid && bit_ready on a clk edge; any cycle, independent of strobe_in.
  - The hold register is emptied when a symbol starts consuming it.
  - If a load and a consume land on the same edge, the consume wins first and the new bit is then loaded (hold stays full). bit_ready is computed from the pre-edge state, so no same-cycle pass-through.
- IDLE:
  - data_out=0, data_valid=0.
  - On a strobe_in with hold_full: phase <= phase XOR bit (bit 1 = pi flip, bit 0 = no change), consume the hold register, n=0, acc=0, k=0, go to RUN.
  - The first sample is emitted on that same strobe.
- RUN, every strobe_in:
  - data_out <= (phase * barker[k]) * AMP, registered.
  - barker = +1,-1,+1,+1,-1,+1,+1,+1,-1,-1,-1 for k=0..10.
  - +1 maps to +AMP, -1 maps to -AMP.
  - data_valid pulses high for one cycle with each update.
- Chip timing: k = floor(n*11/32), realised with an accumulator.
  - acc_next = acc+11; if acc_next >= 32 then acc <= acc_next-32 and k <= k+1, else acc <= acc_next.
  - k runs 0..10 and must never reach 11 within a symbol.
  - Chip-change samples: n = 3, 6, 9, 12, 15, 18, 21, 24, 27, 30 (verify against the formula).
- Symbol boundary: on the strobe where n==31 (last sample):
  - If hold_full: the next strobe starts a new symbol (phase update, n/acc/k cleared, hold consumed), giving continuous output.
  - If hold empty: underrun pulses one cycle; state <= IDLE after the last sample; data_out goes to 0 on the next strobe.
- No strobe_in: the counters, phase and data_out hold their values.
- Latency: a bit held before strobe S appears as sample 0 at data_out one clk after strobe S.
- Phase persists across IDLE gaps; it is reset only by reset. This matches the receiver's differential decode.
- Reset mid-symbol aborts immediately to the reset values. No partial-symbol completion.
- bit_valid while bit_ready=0 is ignored; the source must hold the bit.

Test Plan:
- Reset then one bit=0 with a strobe every 3 clks → 32 samples: +8192,+8192,+8192,-8192,-8192,-8192,+8192×6,-8192×3 …; chip pattern changes exactly at n=3,6,…,30; then underrun pulse and data_out=0.
- Bits 1,0,1 offered back-to-back → three contiguous symbols with no gap. Symbol 1 is inverted versus the Barker pattern (phase -1), symbol 2 is also inverted, symbol 3 is positive. underrun stays 0 until after symbol 3.
- Sum over one symbol of data_out*barker[k(n)] equals ±32*8192; sign matches phase, confirming chip alignment.
- Hold bit_valid high continuously → bit_ready drops after each load, and exactly one bit is accepted per symbol; no bit is lost or duplicated over 10 symbols.
- strobe_in held low for 50 clks mid-symbol → data_out, n and k frozen; output resumes from the same sample.
- Assert reset at n=17 → all outputs zero asynchronously; after release with bit=1, the first symbol uses phase -1 (reset phase +1 flipped).

Source files
------------

// File: rtl/dbpsk_barker_tx.sv
// DBPSK transmitter: differentially encodes one bit per symbol and spreads it with the
// 11-chip Barker code into 32 strobe-paced signed samples.
module dbpsk_barker_tx #(
  parameter logic signed [15:0] AMP   = 16'sd8192,
  parameter int                 SPS   = 32,
  parameter int                 CHIPS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe_in,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Bit k set means chip k is +1; chip 0 is the LSB.
  localparam logic [10:0]        BARKER  = 11'b000_1110_1101;
  localparam logic [5:0]         STEP    = 6'(CHIPS);
  localparam logic [5:0]         WRAP    = 6'(SPS);
  localparam logic [4:0]         LAST_N  = 5'(SPS - 1);
  localparam logic signed [15:0] NEG_AMP = -AMP;

  function automatic logic [15:0] chip_sample(input logic positive);
    logic [15:0] v;
    if (positive) v = AMP;
    else          v = NEG_AMP;
    return v;
  endfunction

  state_t      state_r;
  logic        hold_full_r, hold_bit_r, phase_r;
  logic [4:0]  n_r, acc_r;
  logic [3:0]  k_r;
  logic [15:0] data_out_r;
  logic        data_valid_r, busy_r, underrun_r;

  logic        load_s, start_s, phase_s;
  logic [5:0]  base_acc_s, acc_sum_s;
  logic [3:0]  base_k_s, k_nxt_s;
  logic [4:0]  n_nxt_s, acc_nxt_s;
  logic [15:0] sample_s;

  assign bit_ready  = ~hold_full_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign busy       = busy_r;
  assign underrun   = underrun_r;

  // Symbol start detection, phase update and next chip-accumulator values.
  always_comb begin
    load_s     = bit_valid & ~hold_full_r;
    start_s    = 1'b0;
    phase_s    = phase_r;
    base_acc_s = 6'd0;
    base_k_s   = 4'd0;
    n_nxt_s    = 5'd0;
    acc_nxt_s  = 5'd0;
    k_nxt_s    = 4'd0;
    // In RUN, n==0 only occurs after a boundary that saw a held bit.
    if (strobe_in && hold_full_r && ((state_r == IDLE) || (n_r == 5'd0))) start_s = 1'b1;
    else                                                                  start_s = 1'b0;
    if (start_s) begin
      phase_s    = phase_r ^ hold_bit_r;
      base_acc_s = 6'd0;
      base_k_s   = 4'd0;
      n_nxt_s    = 5'd1;
    end else begin
      phase_s    = phase_r;
      base_acc_s = {1'b0, acc_r};
      base_k_s   = k_r;
      n_nxt_s    = n_r + 5'd1;
    end
    acc_sum_s = base_acc_s + STEP;
    if (acc_sum_s >= WRAP) begin
      acc_nxt_s = 5'(acc_sum_s - WRAP);
      k_nxt_s   = base_k_s + 4'd1;
    end else begin
      acc_nxt_s = acc_sum_s[4:0];
      k_nxt_s   = base_k_s;
    end
    sample_s = chip_sample(BARKER[base_k_s] ^ phase_s);
  end

  // Single-entry hold register; a consume frees the slot before a same-edge load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full_r <= 1'b0;
      hold_bit_r  <= 1'b0;
    end else if (load_s) begin
      hold_full_r <= 1'b1;
      hold_bit_r  <= bit_in;
    end else if (start_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // Symbol sequencer with registered sample outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      phase_r      <= 1'b0;
      n_r          <= 5'd0;
      acc_r        <= 5'd0;
      k_r          <= 4'd0;
      data_out_r   <= 16'd0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      underrun_r   <= 1'b0;
      if (strobe_in) begin
        case (state_r)
          IDLE: begin
            if (start_s) begin
              state_r      <= RUN;
              busy_r       <= 1'b1;
              phase_r      <= phase_s;
              data_out_r   <= sample_s;
              data_valid_r <= 1'b1;
              n_r          <= n_nxt_s;
              acc_r        <= acc_nxt_s;
              k_r          <= k_nxt_s;
            end else begin
              data_out_r <= 16'd0;
            end
          end
          RUN: begin
            phase_r      <= phase_s;
            data_out_r   <= sample_s;
            data_valid_r <= 1'b1;
            if (n_r == LAST_N) begin
              // Clear here so k never advances to 11 past the last sample.
              n_r   <= 5'd0;
              acc_r <= 5'd0;
              k_r   <= 4'd0;
              if (!hold_full_r) begin
                underrun_r <= 1'b1;
                state_r    <= IDLE;
                busy_r     <= 1'b0;
              end else begin
                state_r <= RUN;
              end
            end else begin
              n_r   <= n_nxt_s;
              acc_r <= acc_nxt_s;
              k_r   <= k_nxt_s;
            end
          end
          default: begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            data_out_r <= 16'd0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
